// File: rtl/block_by_drain.sv
// block_by_drain: buffers bx2y rdy/vld words in a DEPTH-entry FIFO and re-issues
// them in order on the by2c req/ack link. Optional statistics under `BY_STATS_EN.
module block_by_drain #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bx2y_vld,
    output logic              bx2y_rdy,
    input  logic [DATA_W-1:0] bx2y_data,
    output logic              by2c_req,
    input  logic              by2c_ack,
    output logic [DATA_W-1:0] by2c_data
`ifdef BY_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_xfer_cnt,
    output logic [CNT_W-1:0]  stat_stall_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_rdy_en;
    logic [DATA_W-1:0] r_out_data;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;

    // r_rdy_en keeps rdy low during reset and for the release edge itself
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign bx2y_rdy  = r_rdy_en & ~w_full;
    assign w_push    = bx2y_vld & bx2y_rdy;
    assign by2c_req  = (r_state == S_REQ);
    assign by2c_data = r_out_data;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (by2c_ack) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rdy_en   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rdy_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_out_data <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bx2y_data;
        end
    end

`ifdef BY_STATS_EN
    logic w_xfer;
    logic w_stall;

    assign w_xfer  = (r_state == S_REQ) & by2c_ack;
    assign w_stall = bx2y_vld & ~bx2y_rdy;

    // clear wins over a same-cycle increment; both counters stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_xfer_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else if (stat_clr) begin
            stat_xfer_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (w_xfer && (stat_xfer_cnt != '1)) begin
                stat_xfer_cnt <= stat_xfer_cnt + 1'b1;
            end
            if (w_stall && (stat_stall_cnt != '1)) begin
                stat_stall_cnt <= stat_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
